program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
Writer side of the instruction-memory interface. The core's program counter and instruction fetch only read instruction memory; this block fills it.
- Receives a byte-serial program frame over a valid/ready stream.
- Writes each program byte into instruction memory through a write port and checks a frame checksum.
- Holds the core stalled (core_run=0) until the image is verified.

Parameters:
ADDR_WIDTH, 8, instruction-memory address width
DATA_WIDTH, 8, instruction/byte width
START_ADDR, 0, first instruction-memory address written by a frame
TIMEOUT_CYCLES, 1024, maximum idle cycles between bytes inside a frame

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  abort or restart; begins a new load
rx_valid  in  1  rx_data holds a byte
rx_data  in  DATA_WIDTH  incoming frame byte
rx_ready  out  1  loader accepts a byte this cycle
im_we  out  1  instruction-memory write strobe
im_addr  out  ADDR_WIDTH  write address
im_wdata  out  DATA_WIDTH  write data
core_run  out  1  core may execute; 0 holds the core
load_done  out  1  one-cycle pulse when a frame is verified
load_error  out  1  sticky error flag

Behaviour:
- Reset (async, active-high) values: state WAIT_LEN, im_we 0, im_addr START_ADDR, im_wdata 0, core_run 0, load_done 0, load_error 0, sum 0, remaining 0, timeout count 0.
- A byte is accepted on a rising edge with rx_valid & rx_ready. rx_ready is combinational from state: 1 in WAIT_LEN, WAIT_DATA and WAIT_SUM; 0 in RUN and ERROR.
- Frame format: length L, then L data bytes, then checksum C. L=0 means 2^ADDR_WIDTH bytes.
- WAIT_LEN, on accept:
  - remaining := L (ADDR_WIDTH+1 bits), sum := L, write pointer := START_ADDR.
  - Go to WAIT_DATA.
  - No timeout in this state.
- WAIT_DATA, on accept of byte D:
  - The next cycle shows im_we=1 for exactly one cycle, with im_addr = pointer and im_wdata = D.
  - The pointer then increments modulo 2^ADDR_WIDTH (wrap-around is legal).
  - sum := (sum + D) mod 256; remaining decrements.
  - Accepting the last byte moves to WAIT_SUM. Its write still occurs on the following cycle.
  - Back-to-back accepts give back-to-back writes; there is no backpressure.
- WAIT_SUM, on accept of C:
  - If (sum + C) mod 256 == 0: go to RUN. load_done pulses for 1 cycle and core_run rises in that same cycle.
  - Otherwise: go to ERROR and set load_error=1.
- RUN: core_run=1. Bytes are ignored.
- ERROR: core_run=0. Remains until start.
- Timeout, in WAIT_DATA and WAIT_SUM:
  - The counter increments every cycle without an accept and clears on each accept.
  - When count reaches TIMEOUT_CYCLES, the next edge moves to ERROR with load_error=1.
  - Any pending im_we from the final accept still completes.
- start (level, sampled at the edge), in any state:
  - Next state is WAIT_LEN; clears sum, remaining, timeout and load_error; core_run goes to 0.
  - start has priority over a simultaneous byte accept; that byte is discarded and not written.
  - A write already registered from the previous cycle still issues.
- Reset mid-frame: im_we, core_run and load_done drop to 0 immediately, asynchronously. Partially written memory contents are left as-is.
- All outputs except rx_ready are registered.

Decomposition:
- Package nrisc_pkg holds:
  - the loader state enum (WAIT_LEN, WAIT_DATA, WAIT_SUM, RUN, ERROR);
  - the byte width constant;
  - the checksum-good constant 8'h00.
- One sub-module, loader_timeout: counter with clear, enable and expired output, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Good frame 03 A1 B2 C3 E7, START_ADDR=0 -> writes (00,A1), (01,B2), (02,C3) on consecutive cycles; load_done pulses once; core_run=1; load_error=0.
- Same frame with checksum E8 -> three writes occur; load_error=1; core_run=0; no load_done; rx_ready=0 until start.
- Length 02, one data byte, then silence -> ERROR exactly TIMEOUT_CYCLES+1 cycles after the accept; exactly one write.
- START_ADDR=F0, length 00, 256 bytes, correct checksum -> 256 writes at addresses F0..FF then 00..EF; load_done.
- start asserted on the same cycle as the 2nd data byte of a 4-byte frame -> that byte is not written; state returns to WAIT_LEN; a new good frame then completes normally.
- reset pulsed mid-frame between edges -> im_we and core_run go to 0 without waiting for a clock edge; after release, state is WAIT_LEN and im_addr=START_ADDR.

Source files
------------

// File: rtl/nrisc_pkg.sv
// Shared types and constants for the program loader: the loader state encoding,
// the byte width and the value that marks a good checksum.
package nrisc_pkg;

    localparam int BYTE_W = 8;
    localparam logic [BYTE_W-1:0] CSUM_GOOD = 8'h00;

    typedef enum logic [2:0] {
        WAIT_LEN  = 3'd0,
        WAIT_DATA = 3'd1,
        WAIT_SUM  = 3'd2,
        RUN       = 3'd3,
        ERROR     = 3'd4
    } loader_state_e;

endpackage

// File: rtl/loader_timeout.sv
// Idle-cycle counter for the loader: counts enabled cycles and holds at the
// limit, where it reports expiry until cleared.
module loader_timeout #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] r_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == LIMIT);

endmodule

// File: rtl/program_loader.sv
// Fills instruction memory from a byte-serial frame (length, data, checksum)
// and releases the core only once the frame checksum verifies.
module program_loader
    import nrisc_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int START_ADDR     = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  rx_valid,
    input  logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_ready,
    output logic                  im_we,
    output logic [ADDR_WIDTH-1:0] im_addr,
    output logic [DATA_WIDTH-1:0] im_wdata,
    output logic                  core_run,
    output logic                  load_done,
    output logic                  load_error,
    output loader_state_e         dbg_state
);

    localparam logic [ADDR_WIDTH-1:0] START   = ADDR_WIDTH'(START_ADDR);
    localparam logic [ADDR_WIDTH:0]   FULL    = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   LAST_ONE = (ADDR_WIDTH+1)'(1);

    loader_state_e           r_state;
    loader_state_e           w_next;
    logic [ADDR_WIDTH:0]     r_remaining;
    logic [BYTE_W-1:0]       r_sum;
    logic [ADDR_WIDTH-1:0]   r_ptr;
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    r_core_run;
    logic                    r_done;
    logic                    r_error;

    logic                    w_acc;
    logic                    w_timed;
    logic                    w_expired;
    logic                    w_tmo;
    logic                    w_take;
    logic [BYTE_W-1:0]       w_sum_chk;
    logic [ADDR_WIDTH:0]     w_len;

    assign rx_ready  = (r_state == WAIT_LEN) || (r_state == WAIT_DATA) || (r_state == WAIT_SUM);
    assign w_acc     = rx_valid && rx_ready;
    assign w_timed   = (r_state == WAIT_DATA) || (r_state == WAIT_SUM);
    assign w_tmo     = w_expired && w_timed;
    // start and an expired timeout both discard a byte offered on the same edge
    assign w_take    = w_acc && !start && !w_tmo;
    assign w_sum_chk = r_sum + rx_data[BYTE_W-1:0];
    assign w_len     = (rx_data[ADDR_WIDTH-1:0] == '0) ? FULL : {1'b0, rx_data[ADDR_WIDTH-1:0]};

    loader_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clock    (clock),
        .reset    (reset),
        .i_clear  (start || w_acc || !w_timed),
        .i_enable (w_timed),
        .o_expired(w_expired)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= WAIT_LEN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (start) begin
            w_next = WAIT_LEN;
        end else begin
            case (r_state)
                WAIT_LEN:  if (w_acc) w_next = WAIT_DATA;
                WAIT_DATA: begin
                    if (w_tmo) w_next = ERROR;
                    else if (w_acc && (r_remaining == LAST_ONE)) w_next = WAIT_SUM;
                end
                WAIT_SUM: begin
                    if (w_tmo) w_next = ERROR;
                    else if (w_acc) w_next = (w_sum_chk == CSUM_GOOD) ? RUN : ERROR;
                end
                default: w_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_remaining <= '0;
            r_sum       <= '0;
            r_ptr       <= START;
            r_we        <= 1'b0;
            r_addr      <= START;
            r_wdata     <= '0;
            r_core_run  <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_we       <= 1'b0;
            r_core_run <= (w_next == RUN);
            r_done     <= (w_next == RUN) && (r_state != RUN);
            r_error    <= (w_next == ERROR);
            if (start) begin
                r_remaining <= '0;
                r_sum       <= '0;
                r_ptr       <= START;
            end else if (w_take) begin
                case (r_state)
                    WAIT_LEN: begin
                        r_remaining <= w_len;
                        r_sum       <= rx_data[BYTE_W-1:0];
                        r_ptr       <= START;
                    end
                    WAIT_DATA: begin
                        r_we        <= 1'b1;
                        r_addr      <= r_ptr;
                        r_wdata     <= rx_data;
                        r_ptr       <= r_ptr + 1'b1;
                        r_sum       <= w_sum_chk;
                        r_remaining <= r_remaining - 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign im_we      = r_we;
    assign im_addr    = r_addr;
    assign im_wdata   = r_wdata;
    assign core_run   = r_core_run;
    assign load_done  = r_done;
    assign load_error = r_error;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: two instances (start address 00 and F0) share one
// stimulus stream; writes are stamped with their cycle and scored against a frame model.
module tb_program_loader;
  import nrisc_pkg::*;

  localparam int TMO = 1024;

  logic clock, reset, start, rx_valid;
  logic [7:0] rx_data;
  logic rdy_a, we_a, run_a, done_a, err_a;
  logic rdy_b, we_b, run_b, done_b, err_b;
  logic [7:0] addr_a, wd_a, addr_b, wd_b;
  loader_state_e st_a, st_b;

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;
  int n_done_a = 0, n_done_b = 0, exp_done = 0;
  logic [47:0] exp_q_a[$], exp_q_b[$], got_a[$], got_b[$];
  logic [7:0] frm[$];

  program_loader #(.START_ADDR(0)) dut_a (
    .clock(clock), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rdy_a), .im_we(we_a), .im_addr(addr_a), .im_wdata(wd_a),
    .core_run(run_a), .load_done(done_a), .load_error(err_a), .dbg_state(st_a));

  program_loader #(.START_ADDR(8'hF0)) dut_b (
    .clock(clock), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rdy_b), .im_we(we_b), .im_addr(addr_b), .im_wdata(wd_b),
    .core_run(run_b), .load_done(done_b), .load_error(err_b), .dbg_state(st_b));

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // write and load_done monitor, sampled mid-cycle
  always @(negedge clock) begin
    if (we_a) got_a.push_back({32'(cyc), addr_a, wd_a});
    if (we_b) got_b.push_back({32'(cyc), addr_b, wd_b});
    if (done_a) n_done_a++;
    if (done_b) n_done_b++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, output int acc_cyc);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clock);
    #1;
    acc_cyc  = cyc;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    @(negedge clock);
    check("start state", 64'(st_a), 64'(WAIT_LEN));
    check("start rx_ready", 64'(rdy_a), 64'd1);
    check("start load_error", 64'(err_a), 64'd0);
    check("start core_run", 64'(run_a), 64'd0);
  endtask

  // reference model: a frame is L, data, C; data byte i lands at base+i
  task automatic build(input int len_field, input bit bad);
    int n;
    logic [7:0] s, d;
    frm.delete();
    n = (len_field % 256 == 0) ? 256 : len_field;
    s = 8'(len_field);
    frm.push_back(8'(len_field));
    for (int i = 0; i < n; i++) begin
      d = 8'($urandom);
      frm.push_back(d);
      s = s + d;
    end
    frm.push_back(8'(8'd0 - s) + (bad ? 8'd1 : 8'd0));
  endtask

  task automatic push_exp(input int c, input int idx, input logic [7:0] d);
    exp_q_a.push_back({32'(c), 8'(idx), d});
    exp_q_b.push_back({32'(c), 8'(8'hF0 + idx), d});
  endtask

  task automatic send_frame(input int max_gap);
    int c;
    for (int i = 0; i < frm.size(); i++) begin
      idle($urandom_range(0, max_gap));
      send(frm[i], c);
      if (i >= 1 && i <= frm.size() - 2) push_exp(c, i - 1, frm[i]);
    end
  endtask

  // scoreboard
  task automatic check_writes(input string tag);
    check({tag, " nwrites_a"}, 64'(got_a.size()), 64'(exp_q_a.size()));
    check({tag, " nwrites_b"}, 64'(got_b.size()), 64'(exp_q_b.size()));
    while (got_a.size() > 0 && exp_q_a.size() > 0)
      check({tag, " write_a"}, 64'(got_a.pop_front()), 64'(exp_q_a.pop_front()));
    while (got_b.size() > 0 && exp_q_b.size() > 0)
      check({tag, " write_b"}, 64'(got_b.pop_front()), 64'(exp_q_b.pop_front()));
    got_a.delete(); got_b.delete(); exp_q_a.delete(); exp_q_b.delete();
  endtask

  task automatic check_outcome(input string tag, input bit ok);
    @(negedge clock);
    check({tag, " load_done"}, 64'(done_a), 64'(ok));
    check({tag, " core_run"}, 64'(run_a), 64'(ok));
    check({tag, " load_error"}, 64'(err_a), 64'(!ok));
    check({tag, " rx_ready"}, 64'(rdy_a), 64'd0);
    check({tag, " state"}, 64'(st_a), ok ? 64'(RUN) : 64'(ERROR));
    check({tag, " load_done_b"}, 64'(done_b), 64'(ok));
    check({tag, " load_error_b"}, 64'(err_b), 64'(!ok));
    @(negedge clock);
    check({tag, " done_pulse"}, 64'(done_a), 64'd0);
    check({tag, " core_run_hold"}, 64'(run_a), 64'(ok));
    check({tag, " error_hold"}, 64'(err_a), 64'(!ok));
    if (ok) exp_done++;
  endtask

  initial begin
    int c;
    logic [7:0] d0;
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    idle(3);
    reset = 1'b0;
    @(negedge clock);
    check("rst im_we", 64'(we_a), 64'd0);
    check("rst im_addr_a", 64'(addr_a), 64'h00);
    check("rst im_addr_b", 64'(addr_b), 64'hF0);
    check("rst im_wdata", 64'(wd_a), 64'h00);
    check("rst core_run", 64'(run_a), 64'd0);
    check("rst load_done", 64'(done_a), 64'd0);
    check("rst load_error", 64'(err_a), 64'd0);
    check("rst rx_ready", 64'(rdy_a), 64'd1);
    check("rst state", 64'(st_a), 64'(WAIT_LEN));

    // directed good frame, back-to-back bytes
    frm = '{8'h03, 8'hA1, 8'hB2, 8'hC3, 8'hE7};
    send_frame(0);
    check_outcome("good", 1'b1);
    check_writes("good");
    send(8'h55, c);
    @(negedge clock);
    check("run ignores byte", 64'(we_a), 64'd0);
    check("run state", 64'(st_a), 64'(RUN));
    check_writes("run ignore");
    pulse_start();

    // same frame, bad checksum
    frm = '{8'h03, 8'hA1, 8'hB2, 8'hC3, 8'hE8};
    send_frame(0);
    check_outcome("badsum", 1'b0);
    send(8'h12, c);
    @(negedge clock);
    check("error rx_ready", 64'(rdy_a), 64'd0);
    check("error core_run", 64'(run_a), 64'd0);
    check_writes("badsum");
    pulse_start();

    // randomized frames with random gaps and checksum quality
    for (int k = 0; k < 6; k++) begin
      bit bad;
      bad = 1'($urandom_range(0, 1));
      build($urandom_range(1, 20), bad);
      send_frame(3);
      check_outcome("rand", !bad);
      check_writes("rand");
      pulse_start();
    end

    // full 256-byte frame, address wrap on instance b
    build(0, 1'b0);
    send_frame(1);
    check_outcome("wrap", 1'b1);
    check_writes("wrap");
    pulse_start();

    // start colliding with the 2nd data byte of a 4-byte frame
    send(8'h04, c);
    d0 = 8'($urandom);
    send(d0, c);
    push_exp(c, 0, d0);
    start = 1'b1; rx_valid = 1'b1; rx_data = 8'h9C;
    @(posedge clock);
    #1;
    start = 1'b0; rx_valid = 1'b0;
    @(negedge clock);
    check("abort no write", 64'(we_a), 64'd0);
    check("abort state", 64'(st_a), 64'(WAIT_LEN));
    check("abort rx_ready", 64'(rdy_a), 64'd1);
    check_writes("abort");
    build(4, 1'b0);
    send_frame(2);
    check_outcome("after abort", 1'b1);
    check_writes("after abort");
    pulse_start();

    // timeout: length 2, one byte, then silence
    send(8'h02, c);
    d0 = 8'($urandom);
    send(d0, c);
    push_exp(c, 0, d0);
    idle(TMO);
    @(negedge clock);
    check("tmo not yet", 64'(st_a), 64'(WAIT_DATA));
    check("tmo no error yet", 64'(err_a), 64'd0);
    idle(1);
    @(negedge clock);
    check("tmo state", 64'(st_a), 64'(ERROR));
    check("tmo load_error", 64'(err_a), 64'd1);
    check("tmo load_error_b", 64'(err_b), 64'd1);
    check("tmo rx_ready", 64'(rdy_a), 64'd0);
    check_writes("tmo");
    pulse_start();

    // asynchronous reset while running
    build(5, 1'b0);
    send_frame(1);
    check_outcome("pre reset", 1'b1);
    check_writes("pre reset");
    #1 reset = 1'b1;
    #1;
    check("areset core_run_a", 64'(run_a), 64'd0);
    check("areset core_run_b", 64'(run_b), 64'd0);
    reset = 1'b0;

    // asynchronous reset mid-frame while a write is showing
    @(negedge clock);
    check("rearm state", 64'(st_a), 64'(WAIT_LEN));
    #1;
    send(8'h05, c);
    d0 = 8'($urandom);
    send(d0, c);
    push_exp(c, 0, d0);
    check("write visible", 64'(we_a), 64'd1);
    @(negedge clock);
    #1 reset = 1'b1;
    #1;
    check("areset im_we_a", 64'(we_a), 64'd0);
    check("areset im_we_b", 64'(we_b), 64'd0);
    reset = 1'b0;
    @(negedge clock);
    check("post reset state", 64'(st_a), 64'(WAIT_LEN));
    check("post reset addr_a", 64'(addr_a), 64'h00);
    check("post reset addr_b", 64'(addr_b), 64'hF0);
    check_writes("mid reset");
    #1;
    build(3, 1'b0);
    send_frame(2);
    check_outcome("recover", 1'b1);
    check_writes("recover");

    check("load_done count a", 64'(n_done_a), 64'(exp_done));
    check("load_done count b", 64'(n_done_b), 64'(exp_done));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
